// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product accelerator: bus instruction encoding,
// register map and STATUS bit positions.
package dot_product_pkg;

    typedef enum logic [1:0] {
        INSTR_NOP   = 2'b00,
        INSTR_READ  = 2'b01,
        INSTR_WRITE = 2'b10,
        INSTR_START = 2'b11
    } instr_e;

    localparam logic [1:0] ADDR_RESULT = 2'd0;
    localparam logic [1:0] ADDR_OPA    = 2'd1;
    localparam logic [1:0] ADDR_OPB    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

endpackage

// File: rtl/dot_product_mac.sv
// Sequential multiply-accumulate engine: snapshots both vectors on start and
// folds in one element product per clock, pulsing o_done on the last element.
module dot_product_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int RES_W      = 2*DATA_WIDTH + $clog2(LENGTH)
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_start,
    input  logic [DATA_WIDTH*LENGTH-1:0] i_a,
    input  logic [DATA_WIDTH*LENGTH-1:0] i_b,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [RES_W-1:0]             o_result
);
    localparam int CNT_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int PROD_W = 2*DATA_WIDTH;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                       r_state, w_next;
    logic [DATA_WIDTH*LENGTH-1:0] r_a, r_b;
    logic [CNT_W-1:0]             r_cnt;
    logic [RES_W-1:0]             r_acc;
    logic [DATA_WIDTH-1:0]        w_ea, w_eb;
    logic [PROD_W-1:0]            w_prod;
    logic [RES_W-1:0]             w_sum;
    logic                         w_last;

    assign w_ea   = r_a[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_eb   = r_b[r_cnt*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod = PROD_W'(w_ea) * PROD_W'(w_eb);
    assign w_sum  = r_acc + RES_W'(w_prod);
    assign w_last = (r_cnt == CNT_W'(LENGTH-1));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_result = w_sum;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    o_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_a   <= i_a;
                r_b   <= i_b;
                r_cnt <= '0;
                r_acc <= '0;
            end
        end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dot_product_accel.sv
// Memory-mapped dot-product accelerator: register file, bus decode and
// registered read port wrapped around the sequential MAC engine.
module dot_product_accel
    import dot_product_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4,
    parameter int MEM_DEPTH  = 4,
    parameter int MEM_WIDTH  = 32
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic [1:0]                   i_instruction,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_address,
    input  logic [MEM_WIDTH-1:0]         i_wr_data,
    output logic [MEM_WIDTH-1:0]         o_rd_data
);
    localparam int RES_W = 2*DATA_WIDTH + $clog2(LENGTH);

    logic [MEM_WIDTH-1:0] r_opa, r_opb, r_result, r_rd_data;
    logic                 r_done;
    logic                 w_start, w_busy, w_done_pulse;
    logic [RES_W-1:0]     w_result;
    logic [MEM_WIDTH-1:0] w_status, w_rd_mux;
    instr_e               w_instr;

    assign w_instr   = instr_e'(i_instruction);
    assign w_start   = (w_instr == INSTR_START);
    assign o_rd_data = r_rd_data;

    dot_product_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .LENGTH     (LENGTH)
    ) u_mac (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_start  (w_start),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_busy   (w_busy),
        .o_done   (w_done_pulse),
        .o_result (w_result)
    );

    always_comb begin
        w_status            = '0;
        w_status[STAT_BUSY] = w_busy;
        w_status[STAT_DONE] = r_done;
        case (i_address)
            ADDR_RESULT: w_rd_mux = r_result;
            ADDR_OPA:    w_rd_mux = r_opa;
            ADDR_OPB:    w_rd_mux = r_opb;
            default:     w_rd_mux = w_status;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_result  <= '0;
            r_rd_data <= '0;
            r_done    <= 1'b0;
        end else begin
            if (w_instr == INSTR_READ) r_rd_data <= w_rd_mux;
            if (w_instr == INSTR_WRITE) begin
                if (i_address == ADDR_OPA) r_opa <= i_wr_data;
                if (i_address == ADDR_OPB) r_opb <= i_wr_data;
            end
            // A START only counts (and clears done) when the engine is idle.
            if (w_start && !w_busy) r_done <= 1'b0;
            if (w_done_pulse) begin
                r_result <= MEM_WIDTH'(w_result);
                r_done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_accel.sv
// Self-checking bench: table of bus operations with expected read data,
// compared through a scoreboard queue, plus hand-written reset sequences.
module tb_dot_product_accel;
    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, ST = 2'b11;

    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b0;
    logic [1:0]  i_instruction = NOP;
    logic [1:0]  i_address = '0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] o_rd_data;

    typedef struct {
        logic [1:0]  ins;
        logic [1:0]  addr;
        logic [31:0] wd;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    bit          t_chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    dot_product_accel dut (
        .i_clk         (i_clk),
        .i_nrst        (i_nrst),
        .i_instruction (i_instruction),
        .i_address     (i_address),
        .i_wr_data     (i_wr_data),
        .o_rd_data     (o_rd_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic vec_t v(logic [1:0] ins, logic [1:0] addr, logic [31:0] wd,
                               bit chk, logic [31:0] exp);
        vec_t r;
        r.ins = ins; r.addr = addr; r.wd = wd; r.chk = chk; r.exp = exp;
        return r;
    endfunction

    task automatic step(input vec_t r);
        @(negedge i_clk);
        i_instruction = r.ins;
        i_address     = r.addr;
        i_wr_data     = r.wd;
        t_chk         = r.chk;
        if (r.chk) sb.push_back(r.exp);
    endtask

    task automatic check_now(input string name, input logic [31:0] exp);
        n_cmp++;
        if (o_rd_data !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, o_rd_data, exp);
        end
    endtask

    // Scoreboard monitor: a checked row's result is visible just after its edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge i_clk);
            if (t_chk) begin
                #1;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard: no expected value queued");
                end else begin
                    e = sb.pop_front();
                    if (o_rd_data !== e) begin
                        n_bad++;
                        $display("FAIL rd_data (t=%0t): got %h expected %h", $time, o_rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h0));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h0));
        // Zero operands
        tbl.push_back(v(WR, 2'd1, 32'h0, 0, 0));
        tbl.push_back(v(WR, 2'd2, 32'h0, 0, 0));
        tbl.push_back(v(ST, 2'd0, 0, 0, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h0));
        // Snapshot: writes during RUN must not disturb the computation
        tbl.push_back(v(WR, 2'd1, 32'h01010101, 0, 0));
        tbl.push_back(v(WR, 2'd2, 32'h01010101, 0, 0));
        tbl.push_back(v(ST, 2'd0, 0, 0, 0));
        tbl.push_back(v(WR, 2'd1, 32'h02020202, 0, 0));
        tbl.push_back(v(WR, 2'd2, 32'h02020202, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h4));
        tbl.push_back(v(NOP, 2'd0, 0, 1, 32'h4));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        // Busy/done timing and RESULT held while busy
        tbl.push_back(v(ST, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h1));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h4));
        tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h10));
        // Mixed operands, START held across busy
        tbl.push_back(v(WR, 2'd1, 32'hAABBCCDD, 0, 0));
        tbl.push_back(v(WR, 2'd2, 32'h11223344, 0, 0));
        tbl.push_back(v(RD, 2'd1, 0, 1, 32'hAABBCCDD));
        tbl.push_back(v(RD, 2'd2, 0, 1, 32'h11223344));
        for (int i = 0; i < 5; i++) tbl.push_back(v(ST, 2'd0, 0, 0, 0));
        tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h00008778));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        // Read-only registers ignore writes
        tbl.push_back(v(WR, 2'd0, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(v(WR, 2'd3, 32'hFFFFFFFF, 0, 0));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h00008778));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        // START held past completion re-triggers on the first idle cycle
        for (int i = 0; i < 6; i++) tbl.push_back(v(ST, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h1));
        for (int i = 0; i < 4; i++) tbl.push_back(v(NOP, 2'd0, 0, 0, 0));
        tbl.push_back(v(RD, 2'd3, 0, 1, 32'h2));
        tbl.push_back(v(RD, 2'd0, 0, 1, 32'h00008778));

        #12;
        check_now("reset_rd_data", 32'h0);
        @(negedge i_clk);
        i_nrst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset in the middle of a computation aborts it
        step(v(RD, 2'd1, 0, 1, 32'hAABBCCDD));
        step(v(ST, 2'd0, 0, 0, 0));
        step(v(NOP, 2'd0, 0, 0, 0));
        @(negedge i_clk);
        i_nrst = 1'b0;
        t_chk  = 1'b0;
        #1;
        check_now("async_reset_rd_data", 32'h0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        step(v(RD, 2'd0, 0, 1, 32'h0));
        step(v(RD, 2'd3, 0, 1, 32'h0));
        for (int i = 0; i < 5; i++) step(v(NOP, 2'd0, 0, 0, 0));
        step(v(RD, 2'd3, 0, 1, 32'h0));
        step(v(RD, 2'd1, 0, 1, 32'h0));
        step(v(WR, 2'd0, 32'h12345678, 0, 0));
        step(v(WR, 2'd3, 32'h87654321, 0, 0));
        step(v(RD, 2'd0, 0, 1, 32'h0));
        step(v(RD, 2'd3, 0, 1, 32'h0));
        step(v(NOP, 2'd0, 0, 0, 0));
        repeat (2) @(negedge i_clk);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dot_product_accel.md
Name: dot_product_accel

Overview:
- Memory-mapped dot-product accelerator with a register-bus-style front end.
- A host writes two packed operand vectors into a 4-word register file, issues a start instruction, polls status, and reads back the result.
- Internally, a sequential multiply-accumulate engine processes one element per clock.
- This is the top-level compute block of the subsystem.

Parameters:
- DATA_WIDTH, 8: width of one unsigned vector element.
- LENGTH, 4: elements per vector; DATA_WIDTH*LENGTH must equal MEM_WIDTH.
- MEM_DEPTH, 4: number of register-file words; fixed at 4.
- MEM_WIDTH, 32: register-file word width and bus data width.

Ports:
- i_clk  input  1  single clock; all logic is on its rising edge.
- i_nrst  input  1  asynchronous active-low reset.
- i_instruction  input  2  00 = NOP, 01 = READ, 10 = WRITE, 11 = START.
- i_address  input  $clog2(MEM_DEPTH)  register word address.
- i_wr_data  input  MEM_WIDTH  write data, used only on WRITE.
- o_rd_data  output  MEM_WIDTH  registered read data.

Behaviour:
- Register map:
  - 0 = RESULT (read-only).
  - 1 = OPERAND_A (R/W).
  - 2 = OPERAND_B (R/W).
  - 3 = STATUS (read-only): bit0 = busy, bit1 = done, other bits 0.
- Reset (asynchronous, i_nrst = 0): all registers, o_rd_data, busy, done and the accumulator clear to 0; the FSM goes to IDLE.
- READ: on the clock edge, o_rd_data <= reg[i_address].
  - Data is visible one cycle after the READ is sampled.
  - o_rd_data holds its last value on every non-READ instruction.
- WRITE: on the clock edge, reg[i_address] <= i_wr_data for addresses 1 and 2.
  - Writes to 0 and 3 are silently ignored.
  - Writes are accepted while busy and do not affect the computation in flight.
- Element i of a vector is bits [i*DATA_WIDTH +: DATA_WIDTH]; element 0 is in the LSBs.
- Result = sum over i of A[i]*B[i], unsigned, exact width 2*DATA_WIDTH + $clog2(LENGTH), zero-extended to MEM_WIDTH.
- FSM states:
  - IDLE: on START, snapshot A and B into internal working registers, clear the accumulator, set busy = 1, clear done, go to RUN.
  - RUN: accumulate one product per cycle for LENGTH cycles. On the final element, write the accumulator plus the final product to RESULT, set busy = 0 and done = 1, then return to IDLE.
- Latency: STATUS reads busy from the edge after START; RESULT and done update exactly LENGTH cycles after START is sampled.
- START while busy is ignored.
- START held for several cycles re-triggers a new computation on the first IDLE cycle after completion, using the operands current at that edge.
- done is sticky until the next accepted START or reset.
- While busy, RESULT keeps its previous value until the update.
- NOP and unused encodings have no side effects.
- Reset mid-computation aborts it: RESULT = 0, busy = 0, done = 0.

Decomposition:
- Package dot_product_pkg:
  - instruction enum (NOP, READ, WRITE, START).
  - address constants (ADDR_RESULT = 0, ADDR_OPA = 1, ADDR_OPB = 2, ADDR_STATUS = 3).
  - status bit indices.
- One sub-module: dot_product_mac.
  - Inputs: start, A, B.
  - Outputs: busy, done pulse, result.
  - Contains the snapshot registers, element counter, multiplier and accumulator.
- The top module holds the register file, bus decode and read-data register.

Test Plan:
- Reset, then READ addr 3 -> o_rd_data = 0x00000000; READ addr 0 -> 0x00000000.
- WRITE A = 0x00000000, B = 0x00000000, START, wait 6 cycles, READ 3 -> 0x00000002; READ 0 -> 0x00000000.
- WRITE A = B = 0x01010101, START, then WRITE A = B = 0x02020202 on the next cycles -> after completion RESULT = 0x00000004 (snapshot kept).
- START again with the 0x02020202 operands -> RESULT = 0x00000010; READ 3 one cycle after START -> bit0 = 1, then 0x00000002 after LENGTH cycles.
- WRITE A = 0xAABBCCDD, B = 0x11223344; READ 1 and READ 2 return the written values; START held 5 cycles -> RESULT = 0x00008778, and the START issued while busy causes no corruption.
- Assert i_nrst = 0 mid-RUN -> o_rd_data, RESULT and STATUS read 0 after release; WRITE to addr 0 or 3 -> the register is unchanged.
